// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: packs fields and a 32-bit immediate into an instruction word
// and emits it on a registered write port. Immediate legality checking is enabled by INSTR_ENC_IMM_CHECK_EN.
module instr_encoder #(
  parameter int unsigned         ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [2:0]        In_Fmt,
  input  logic [6:0]        In_Opcode,
  input  logic [4:0]        In_Rd,
  input  logic [4:0]        In_Rs1,
  input  logic [4:0]        In_Rs2,
  input  logic [2:0]        In_Funct3,
  input  logic [6:0]        In_Funct7,
  input  logic [31:0]       In_Imm,
  input  logic              Addr_Load,
  input  logic [ADDR_W-1:0] Addr_In,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [ADDR_W-1:0] Out_Addr,
  output logic [31:0]       Out_Data,
  output logic              Imm_Err,
  output logic [7:0]        Err_Count
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_J = 3'd4,
    FMT_U = 3'd5
  } fmt_t;

  logic [31:0]       word;
  logic              legal;
  logic              shift_op;
  logic              accept;
  logic              emit;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] word_addr;

  assign shift_op = (In_Funct3 == 3'b001) || (In_Funct3 == 3'b101);
  assign In_Ready = !Out_Valid || Out_Ready;
  assign accept   = In_Valid && In_Ready;
  assign emit     = accept && legal;

  always_comb begin
    word = {In_Funct7, In_Rs2, In_Rs1, In_Funct3, In_Rd, In_Opcode};
    case (fmt_t'(In_Fmt))
      FMT_I: begin
        if (shift_op)
          word = {In_Funct7, In_Imm[4:0], In_Rs1, In_Funct3, In_Rd, In_Opcode};
        else
          word = {In_Imm[11:0], In_Rs1, In_Funct3, In_Rd, In_Opcode};
      end
      FMT_S: word = {In_Imm[11:5], In_Rs2, In_Rs1, In_Funct3, In_Imm[4:0], In_Opcode};
      FMT_B: word = {In_Imm[12], In_Imm[10:5], In_Rs2, In_Rs1, In_Funct3,
                     In_Imm[4:1], In_Imm[11], In_Opcode};
      FMT_J: word = {In_Imm[20], In_Imm[10:1], In_Imm[11], In_Imm[19:12], In_Rd, In_Opcode};
      FMT_U: word = {In_Imm[19:0], In_Rd, In_Opcode};
      default: ;
    endcase
  end

`ifdef INSTR_ENC_IMM_CHECK_EN
  always_comb begin
    legal = 1'b1;
    case (fmt_t'(In_Fmt))
      FMT_I: begin
        if (shift_op)
          legal = (In_Imm[31:5] == '0);
        else
          legal = (In_Imm == {{20{In_Imm[11]}}, In_Imm[11:0]});
      end
      FMT_S: legal = (In_Imm == {{20{In_Imm[11]}}, In_Imm[11:0]});
      FMT_B: legal = (In_Imm == {{19{In_Imm[12]}}, In_Imm[12:0]}) && !In_Imm[0];
      FMT_J: legal = (In_Imm == {{11{In_Imm[20]}}, In_Imm[20:0]}) && !In_Imm[0];
      FMT_U: legal = (In_Imm == {{12{In_Imm[19]}}, In_Imm[19:0]});
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Imm_Err   <= 1'b0;
      Err_Count <= '0;
    end else begin
      Imm_Err <= accept && !legal;
      if (accept && !legal && (Err_Count != 8'hFF))
        Err_Count <= Err_Count + 8'd1;
    end
  end
`else
  logic unused_imm_hi;

  assign legal         = 1'b1;
  assign Imm_Err       = 1'b0;
  assign Err_Count     = '0;
  assign unused_imm_hi = ^In_Imm[31:21];
`endif

  // A load in the same cycle as an emit addresses the emitted word itself.
  assign word_addr = Addr_Load ? Addr_In : addr_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Out_Valid <= 1'b0;
      Out_Data  <= '0;
      Out_Addr  <= '0;
      addr_cnt  <= BASE_ADDR;
    end else begin
      if (emit) begin
        Out_Valid <= 1'b1;
        Out_Data  <= word;
        Out_Addr  <= word_addr;
      end else if (Out_Ready) begin
        Out_Valid <= 1'b0;
      end

      if (emit)
        addr_cnt <= word_addr + ADDR_W'(4);
      else if (Addr_Load)
        addr_cnt <= Addr_In;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; expectations follow INSTR_ENC_IMM_CHECK_EN if defined.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        addr_load;
  logic [31:0] addr_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        imm_err;
  logic [7:0]  err_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .Clk(clk), .Reset(rst),
    .In_Valid(in_valid), .In_Ready(in_ready), .In_Fmt(in_fmt), .In_Opcode(in_opcode),
    .In_Rd(in_rd), .In_Rs1(in_rs1), .In_Rs2(in_rs2), .In_Funct3(in_funct3),
    .In_Funct7(in_funct7), .In_Imm(in_imm),
    .Addr_Load(addr_load), .Addr_In(addr_in),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Out_Addr(out_addr), .Out_Data(out_data),
    .Imm_Err(imm_err), .Err_Count(err_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  // One-cycle request; returns #1 after the accepting edge.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    set_fields(fmt, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    addr_load = 1'b0;
  endtask

  initial begin
    int unsigned snt, rcv, stall;
    logic [31:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; addr_load = 1'b0; addr_in = '0;
    set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_out_addr", out_addr, 32'h0);
    check_eq("rst_imm_err", {31'd0, imm_err}, 32'd0);
    check_eq("rst_err_count", {24'd0, err_count}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADDI x1, x2, -2048
    send(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'hFFFFF800);
    check_eq("addi_valid", {31'd0, out_valid}, 32'd1);
    check_eq("addi_data", out_data, 32'h80010093);
    check_eq("addi_addr", out_addr, 32'h0);

    send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFFFFFC);
    check_eq("beq_data", out_data, 32'hFE208EE3);
    check_eq("beq_addr", out_addr, 32'h4);

    send(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'b000, 7'b0100000, 32'hDEADBEEF);
    check_eq("sub_data", out_data, 32'h403100B3);
    check_eq("sub_addr", out_addr, 32'h8);

    send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'hFFFFFFF8);
    check_eq("sw_data", out_data, 32'hFE20AC23);
    check_eq("sw_addr", out_addr, 32'hC);

    send(3'd1, 7'b0010011, 5'd5, 5'd6, 5'd0, 3'b101, 7'b0100000, 32'd7);
    check_eq("srai_data", out_data, 32'h40735293);
    check_eq("srai_addr", out_addr, 32'h10);

    send(3'd5, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00012345);
    check_eq("lui_data", out_data, 32'h123451B7);
    check_eq("lui_addr", out_addr, 32'h14);

    send(3'd7, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'b000, 7'b0100000, 32'h0);
    check_eq("fmt7_data", out_data, 32'h403100B3);

    send(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8);
    check_eq("jal_data", out_data, 32'h008000EF);
    check_eq("jal_addr", out_addr, 32'h1C);

    // Odd JAL offset, issued while the previous word drains
    send(3'd4, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00000801);
`ifdef INSTR_ENC_IMM_CHECK_EN
    check_eq("jodd_valid", {31'd0, out_valid}, 32'd0);
    check_eq("jodd_err", {31'd0, imm_err}, 32'd1);
    check_eq("jodd_cnt", {24'd0, err_count}, 32'd1);
`else
    check_eq("jodd_valid", {31'd0, out_valid}, 32'd1);
    check_eq("jodd_data", out_data, 32'h0010006F);
    check_eq("jodd_addr", out_addr, 32'h20);
    check_eq("jodd_err", {31'd0, imm_err}, 32'd0);
`endif
    send(3'd5, 7'b0010111, 5'd4, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00000001);
    check_eq("after_j_err", {31'd0, imm_err}, 32'd0);
`ifdef INSTR_ENC_IMM_CHECK_EN
    check_eq("after_j_addr", out_addr, 32'h20);
`else
    check_eq("after_j_addr", out_addr, 32'h24);
`endif
    check_eq("auipc_data", out_data, 32'h00001217);

    // Address load with a simultaneous accept, then wrap
    addr_load = 1'b1; addr_in = 32'hFFFFFFFC;
    send(3'd5, 7'b0110111, 5'd7, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00000ABC);
    check_eq("load_addr", out_addr, 32'hFFFFFFFC);
    check_eq("load_data", out_data, 32'h00ABC3B7);
    send(3'd5, 7'b0110111, 5'd8, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00000001);
    check_eq("wrap_addr", out_addr, 32'h0);

    // Reset while a word is held
    out_ready = 1'b0;
    send(3'd5, 7'b0110111, 5'd9, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00000002);
    check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
    check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mrst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mrst_data", out_data, 32'h0);
    check_eq("mrst_err_count", {24'd0, err_count}, 32'd0);
    check_eq("mrst_in_ready", {31'd0, in_ready}, 32'd1);

    // Four-word stream; word 1 is stalled for 3 cycles. Word k = LUI x(k+1), k+1.
    out_ready = 1'b1;
    snt = 0; rcv = 0; stall = 0; held = '0;
    for (int cyc = 0; cyc < 30 && rcv < 4; cyc++) begin
      in_valid = (snt < 4);
      set_fields(3'd5, 7'b0110111, 5'(snt + 1), 5'd0, 5'd0, 3'b000, 7'd0, 32'(snt + 1));
      out_ready = !(out_valid && rcv == 1 && stall < 3);
      #1;
      if (!out_ready) begin
        if (stall == 0) held = out_data;
        stall++;
        check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("stall_data", out_data, 32'h00002137);
        check_eq("stall_stable", out_data, held);
        check_eq("stall_addr", out_addr, 32'h4);
      end
      if (out_valid && out_ready) begin
        check_eq("stream_data", out_data, ((rcv + 1) << 12) | ((rcv + 1) << 7) | 32'h37);
        check_eq("stream_addr", out_addr, rcv * 4);
        rcv++;
      end
      if (in_valid && in_ready) snt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_eq("stream_count", rcv, 32'd4);
    check_eq("stream_stalls", stall, 32'd3);
    @(posedge clk); #1;
    check_eq("stream_drained", {31'd0, out_valid}, 32'd0);

    // 256 out-of-range U immediates
    for (int n = 0; n < 256; n++)
      send(3'd5, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00100000);
`ifdef INSTR_ENC_IMM_CHECK_EN
    check_eq("sat_err_count", {24'd0, err_count}, 32'd255);
    check_eq("sat_valid", {31'd0, out_valid}, 32'd0);
`else
    check_eq("sat_err_count", {24'd0, err_count}, 32'd0);
    check_eq("trunc_u_data", out_data, 32'h000000B7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
